mdu_ctrl: RTL

Iterative multiply/divide unit with integrated funct decode for the MIPS execute stage. It implements the R-type MULT, MULTU, DIV, DIVU, MTHI and MTLO funct codes, and owns the architectural HI/LO registers. It sits beside the single-cycle ALU. The main-pipeline decode asserts `start` with the funct code and operands, and stalls while `busy` is high.

---
 rtl/mdu_ctrl_if.sv | 16 +
 rtl/mdu_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute-stage handshake and HI/LO bus between pipeline decode and the multiply/divide unit
// Ports: start, flush, funct, rs_val, rt_val (pipeline -> mdu); busy, done, hi, lo (mdu -> pipeline)
// master = pipeline side, slave = mdu side; WIDTH must match the mdu_ctrl instance.
interface mdu_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic             flush;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, flush, funct, rs_val, rt_val, input busy, done, hi, lo);
  modport slave  (input start, flush, funct, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU unit with MTHI/MTLO, owning the HI/LO registers
// Ports: clk, rst_n (async active-low), bus (mdu_ctrl_if.slave: start/flush/funct/rs_val/rt_val in,
//        busy/done/hi/lo out). Optional macro MDU_EARLY_OUT_EN ends a multiply once the remaining
//        multiplier bits are all zero.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  mdu_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  state_t             state;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [CW-1:0]      cnt;
  // acc: product for multiply, {remainder, dividend/quotient} for divide
  logic [2*WIDTH-1:0] acc;
  // mc: shifted multiplicand for multiply, raw rs_val for divide (divide-by-zero HI)
  logic [2*WIDTH-1:0] mc;
  // b: multiplier magnitude (shifted right each cycle) or divisor magnitude
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               is_md;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               last;
  // funct 0110xy: x=1 divide, y=1 unsigned
  assign is_md  = bus.funct[5:2] == 4'b0110;
  assign rs_neg = ~bus.funct[0] & bus.rs_val[WIDTH-1];
  assign rt_neg = ~bus.funct[0] & bus.rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;
  always_comb begin
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, b};
    acc_nx = op_div ? {ge ? rem_sh[WIDTH-1:0] - b : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                    : (b[0] ? acc + mc : acc);
    prod   = neg_q ? -acc : acc;
    q_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
`ifdef MDU_EARLY_OUT_EN
  // b still holds the bit consumed this cycle, so the rest is b[WIDTH-1:1]
  assign last = (cnt == CW'(WIDTH-1)) | (~op_div & ~|b[WIDTH-1:1]);
`else
  assign last = cnt == CW'(WIDTH-1);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mc     <= '0;
      b      <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && is_md) begin
              state  <= CALC;
              op_div <= bus.funct[1];
              neg_q  <= rs_neg ^ rt_neg;
              neg_r  <= rs_neg;
              dz     <= bus.funct[1] & ~|bus.rt_val;
              cnt    <= '0;
              acc    <= bus.funct[1] ? {{WIDTH{1'b0}}, rs_mag} : '0;
              mc     <= {{WIDTH{1'b0}}, bus.funct[1] ? bus.rs_val : rs_mag};
              b      <= rt_mag;
            end else if (bus.start && bus.funct == F_MTHI) begin
              hi_q <= bus.rs_val;
            end else if (bus.start && bus.funct == F_MTLO) begin
              lo_q <= bus.rs_val;
            end
          end
          CALC: begin
            acc <= acc_nx;
            mc  <= op_div ? mc : mc << 1;
            b   <= op_div ? b : b >> 1;
            cnt <= cnt + 1'b1;
            if (last) state <= FIXUP;
          end
          FIXUP: begin
            hi_q   <= !op_div ? prod[2*WIDTH-1:WIDTH] : (dz ? mc[WIDTH-1:0] : r_fix);
            lo_q   <= !op_div ? prod[WIDTH-1:0] : (dz ? '1 : q_fix);
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
